// File: rtl/mem_arbiter.sv
// Two-client round-robin arbiter onto one pipelined memory port; grants are held per burst and an
// in-order owner FIFO routes read responses. Define ARB_PERF_CNT_EN to add grant/conflict counters.
module mem_arbiter #(
   parameter int unsigned OUTSTANDING = 4,
   parameter int unsigned MAX_BURST   = 8
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [31:0] i_c0_addr,
   input  logic        i_c0_ren,
   input  logic        i_c0_wen,
   input  logic [31:0] i_c0_wdata,
   output logic        o_c0_ready,
   output logic        o_c0_valid,
   output logic [31:0] o_c0_rdata,
   input  logic [31:0] i_c1_addr,
   input  logic        i_c1_ren,
   input  logic        i_c1_wen,
   input  logic [31:0] i_c1_wdata,
   output logic        o_c1_ready,
   output logic        o_c1_valid,
   output logic [31:0] o_c1_rdata,
   input  logic        i_mem_ready,
   output logic [31:0] o_mem_addr,
   output logic        o_mem_ren,
   output logic        o_mem_wen,
   output logic [3:0]  o_mem_mask,
   output logic [31:0] o_mem_wdata,
`ifdef ARB_PERF_CNT_EN
   output logic [31:0] o_grant_cnt0,
   output logic [31:0] o_grant_cnt1,
   output logic [31:0] o_conflict_cnt,
`endif
   input  logic        i_mem_valid,
   input  logic [31:0] i_mem_rdata
);

   localparam int unsigned PtrW   = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int unsigned BurstW = $clog2(MAX_BURST + 1);
   localparam logic [PtrW:0]   FifoDepth = (PtrW + 1)'(OUTSTANDING);
   localparam logic [PtrW-1:0] PtrLast   = PtrW'(OUTSTANDING - 1);
   localparam logic [BurstW:0] BurstMax  = (BurstW + 1)'(MAX_BURST);

   typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

   state_e              state_q, state_d;
   logic                rr_q, rr_d;
   logic [BurstW-1:0]   burst_q, burst_d;
   logic [OUTSTANDING-1:0] fifo_id_q;
   logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]       fifo_cnt_q;

   logic            req0, req1, owner_valid, owner_id, own_ren, own_wen, other_req;
   logic            fifo_empty, fifo_full, pop, push, block_rd, beat;
   logic [BurstW:0] burst_sum;

   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
      return (p == PtrLast) ? '0 : p + 1'b1;
   endfunction

   assign req0        = i_c0_ren | i_c0_wen;
   assign req1        = i_c1_ren | i_c1_wen;
   assign owner_valid = (state_q != StIdle);
   assign owner_id    = (state_q == StOwn1);
   assign own_ren     = owner_id ? i_c1_ren : i_c0_ren;
   assign own_wen     = owner_id ? i_c1_wen : i_c0_wen;
   assign other_req   = owner_id ? req0 : req1;
   assign fifo_empty  = (fifo_cnt_q == '0);
   assign fifo_full   = (fifo_cnt_q == FifoDepth);
   assign pop         = i_mem_valid & ~fifo_empty;
   // A response popping this cycle frees the slot that a full FIFO would otherwise deny.
   assign block_rd    = fifo_full & ~pop;
   assign beat        = owner_valid & (own_ren | own_wen) & i_mem_ready & ~(own_ren & block_rd);
   assign push        = beat & own_ren;
   assign burst_sum   = {1'b0, burst_q} + (BurstW + 1)'(beat);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= StIdle;
         rr_q    <= 1'b0;
         burst_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         burst_q <= burst_d;
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      burst_d = burst_q;
      unique case (state_q)
         StIdle: begin
            burst_d = '0;
            if (req0 && req1) begin
               state_d = rr_q ? StOwn1 : StOwn0;
               rr_d    = ~rr_q;
            end else if (req0) begin
               state_d = StOwn0;
               rr_d    = 1'b1;
            end else if (req1) begin
               state_d = StOwn1;
               rr_d    = 1'b0;
            end
         end
         StOwn0, StOwn1: begin
            burst_d = (burst_sum >= BurstMax) ? BurstMax[BurstW-1:0] : burst_sum[BurstW-1:0];
            if (!(own_ren || own_wen) || (other_req && burst_sum >= BurstMax)) begin
               burst_d = '0;
               if (other_req) state_d = owner_id ? StOwn0 : StOwn1;
               else           state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      o_mem_addr  = '0;
      o_mem_ren   = 1'b0;
      o_mem_wen   = 1'b0;
      o_mem_wdata = '0;
      o_c0_ready  = 1'b0;
      o_c1_ready  = 1'b0;
      unique case (state_q)
         StOwn0: begin
            o_mem_addr  = i_c0_addr;
            o_mem_ren   = i_c0_ren & ~block_rd;
            o_mem_wen   = i_c0_wen;
            o_mem_wdata = i_c0_wdata;
            o_c0_ready  = i_mem_ready & ~(i_c0_ren & block_rd);
         end
         StOwn1: begin
            o_mem_addr  = i_c1_addr;
            o_mem_ren   = i_c1_ren & ~block_rd;
            o_mem_wen   = i_c1_wen;
            o_mem_wdata = i_c1_wdata;
            o_c1_ready  = i_mem_ready & ~(i_c1_ren & block_rd);
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         fifo_id_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         fifo_cnt_q <= '0;
      end else begin
         if (push) begin
            fifo_id_q[wr_ptr_q] <= owner_id;
            wr_ptr_q            <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (push && !pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
         else if (pop && !push) fifo_cnt_q <= fifo_cnt_q - 1'b1;
      end
   end

   assign o_c0_valid = pop & ~fifo_id_q[rd_ptr_q];
   assign o_c1_valid = pop & fifo_id_q[rd_ptr_q];
   assign o_c0_rdata = o_c0_valid ? i_mem_rdata : '0;
   assign o_c1_rdata = o_c1_valid ? i_mem_rdata : '0;
   assign o_mem_mask = 4'b1111;

`ifndef SYNTHESIS
   always_ff @(posedge i_clk) begin
      if (!i_rst && i_mem_valid && fifo_empty) begin
         $error("mem_arbiter: read response with no outstanding read");
      end
   end
`endif

`ifdef ARB_PERF_CNT_EN
   logic [31:0] grant_cnt0_q, grant_cnt1_q, conflict_cnt_q;
   logic        conflict;

   assign conflict = (req0 && state_q != StOwn0) || (req1 && state_q != StOwn1);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         grant_cnt0_q   <= '0;
         grant_cnt1_q   <= '0;
         conflict_cnt_q <= '0;
      end else begin
         if (beat && !owner_id) grant_cnt0_q <= grant_cnt0_q + 1'b1;
         if (beat && owner_id)  grant_cnt1_q <= grant_cnt1_q + 1'b1;
         if (conflict)          conflict_cnt_q <= conflict_cnt_q + 1'b1;
      end
   end

   assign o_grant_cnt0   = grant_cnt0_q;
   assign o_grant_cnt1   = grant_cnt1_q;
   assign o_conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: drives both clients and a latency memory, checking every
// output each cycle against a queue-based ownership/response model.
module tb_mem_arbiter;

   localparam int OUTSTANDING = 4;
   localparam int MAX_BURST   = 8;
   localparam int LATENCY     = 3;
   localparam int NPH         = 6;

   logic             clk, rst;
   logic [1:0]       c_ren, c_wen, c_ready, c_valid;
   logic [1:0][31:0] c_addr, c_wdata, c_rdata;
   logic             mem_ready, mem_ren, mem_wen, mem_valid;
   logic [31:0]      mem_addr, mem_wdata, mem_rdata;
   logic [3:0]       mem_mask;

   mem_arbiter #(.OUTSTANDING(OUTSTANDING), .MAX_BURST(MAX_BURST)) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_c0_addr   (c_addr[0]),
      .i_c0_ren    (c_ren[0]),
      .i_c0_wen    (c_wen[0]),
      .i_c0_wdata  (c_wdata[0]),
      .o_c0_ready  (c_ready[0]),
      .o_c0_valid  (c_valid[0]),
      .o_c0_rdata  (c_rdata[0]),
      .i_c1_addr   (c_addr[1]),
      .i_c1_ren    (c_ren[1]),
      .i_c1_wen    (c_wen[1]),
      .i_c1_wdata  (c_wdata[1]),
      .o_c1_ready  (c_ready[1]),
      .o_c1_valid  (c_valid[1]),
      .o_c1_rdata  (c_rdata[1]),
      .i_mem_ready (mem_ready),
      .o_mem_addr  (mem_addr),
      .o_mem_ren   (mem_ren),
      .o_mem_wen   (mem_wen),
      .o_mem_mask  (mem_mask),
      .o_mem_wdata (mem_wdata),
      .i_mem_valid (mem_valid),
      .i_mem_rdata (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] data;
   } resp_t;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   // Reference model: owner is -1 when nobody holds the port.
   int          owner, rr, beats;
   int          owner_q[$];
   resp_t       resp_q[$];
   logic [31:0] mem_arr [logic [31:0]];
   bit          active [2];

   int unsigned start_pct, stay_pct, ren_pct, ready_pct, valid_pct;
   int unsigned ph_start [NPH] = '{30, 100, 50, 60, 70, 40};
   int unsigned ph_stay  [NPH] = '{60, 100, 90, 80, 90, 70};
   int unsigned ph_ren   [NPH] = '{60,  50, 90, 50, 80, 60};
   int unsigned ph_ready [NPH] = '{80, 100, 90, 60, 90, 70};
   int unsigned ph_valid [NPH] = '{70,  80,  0, 50,  0, 100};
   int          ph_len   [NPH] = '{300, 200, 60, 600, 40, 300};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      return mem_arr.exists(a) ? mem_arr[a] : (a * 32'h9E37_79B9) ^ 32'h5A5A_0000;
   endfunction

   task automatic reset_model();
      owner  = -1;
      rr     = 0;
      beats  = 0;
      owner_q.delete();
      resp_q.delete();
      active = '{1'b0, 1'b0};
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_mem_addr"},  mem_addr, 32'h0);
      check_eq({tag, "_mem_ren"},   32'(mem_ren), 32'h0);
      check_eq({tag, "_mem_wen"},   32'(mem_wen), 32'h0);
      check_eq({tag, "_mem_wdata"}, mem_wdata, 32'h0);
      check_eq({tag, "_mem_mask"},  32'(mem_mask), 32'hF);
      check_eq({tag, "_ready"},     32'(c_ready), 32'h0);
      check_eq({tag, "_valid"},     32'(c_valid), 32'h0);
      check_eq({tag, "_rdata0"},    c_rdata[0], 32'h0);
      check_eq({tag, "_rdata1"},    c_rdata[1], 32'h0);
   endtask

   task automatic drive_inputs();
      for (int k = 0; k < 2; k++) begin
         if (active[k]) active[k] = ($urandom_range(0, 99) < stay_pct);
         else           active[k] = ($urandom_range(0, 99) < start_pct);
         c_ren[k] = 1'b0;
         c_wen[k] = 1'b0;
         if (active[k]) begin
            if ($urandom_range(0, 99) < ren_pct) c_ren[k] = 1'b1;
            else                                 c_wen[k] = 1'b1;
         end
         c_addr[k]  = 32'($urandom_range(0, 31));
         c_wdata[k] = $urandom;
      end
      mem_ready = ($urandom_range(0, 99) < ready_pct);
      mem_valid = 1'b0;
      mem_rdata = '0;
      if (resp_q.size() > 0 && resp_q[0].due <= cyc && $urandom_range(0, 99) < valid_pct) begin
         mem_valid = 1'b1;
         mem_rdata = resp_q[0].data;
      end
   endtask

   task automatic check_cycle();
      logic [1:0]       req, e_rdy, e_valid;
      logic [1:0][31:0] e_rdata;
      logic [31:0]      e_addr, e_wd;
      logic             e_ren, e_wen, full, pop, beat;
      int               o;

      req    = c_ren | c_wen;
      // A full owner list still takes a read when a response leaves in the same cycle.
      full   = (owner_q.size() == OUTSTANDING) && !mem_valid;
      e_addr = '0;
      e_wd   = '0;
      e_ren  = 1'b0;
      e_wen  = 1'b0;
      e_rdy  = '0;
      if (owner >= 0) begin
         e_addr       = c_addr[owner];
         e_wd         = c_wdata[owner];
         e_ren        = c_ren[owner] && !full;
         e_wen        = c_wen[owner];
         e_rdy[owner] = mem_ready && !(c_ren[owner] && full);
      end
      pop = mem_valid && owner_q.size() > 0;
      for (int k = 0; k < 2; k++) begin
         e_valid[k] = pop && owner_q[0] == k;
         e_rdata[k] = e_valid[k] ? mem_rdata : 32'h0;
      end

      check_eq("c0_ready",  32'(c_ready[0]), 32'(e_rdy[0]));
      check_eq("c1_ready",  32'(c_ready[1]), 32'(e_rdy[1]));
      check_eq("c0_valid",  32'(c_valid[0]), 32'(e_valid[0]));
      check_eq("c1_valid",  32'(c_valid[1]), 32'(e_valid[1]));
      check_eq("c0_rdata",  c_rdata[0], e_rdata[0]);
      check_eq("c1_rdata",  c_rdata[1], e_rdata[1]);
      check_eq("mem_addr",  mem_addr, e_addr);
      check_eq("mem_ren",   32'(mem_ren), 32'(e_ren));
      check_eq("mem_wen",   32'(mem_wen), 32'(e_wen));
      check_eq("mem_wdata", mem_wdata, e_wd);
      check_eq("mem_mask",  32'(mem_mask), 32'hF);

      beat = (owner >= 0) && req[owner] && e_rdy[owner];
      if (pop) void'(owner_q.pop_front());
      if (beat && c_ren[owner]) owner_q.push_back(owner);

      // Memory side reacts to what the arbiter actually presents.
      if (mem_valid && resp_q.size() > 0) void'(resp_q.pop_front());
      if (mem_ready && mem_wen) mem_arr[mem_addr] = mem_wdata;
      if (mem_ready && mem_ren) resp_q.push_back('{due: cyc + LATENCY, data: mem_read(mem_addr)});

      if (owner < 0) begin
         if (req != 2'b00) begin
            owner = (req == 2'b11) ? rr : (req[1] ? 1 : 0);
            rr    = 1 - owner;
            beats = 0;
         end
      end else begin
         o     = 1 - owner;
         beats = beats + (beat ? 1 : 0);
         if (!req[owner] || (req[o] && beats >= MAX_BURST)) begin
            owner = req[o] ? o : -1;
            beats = 0;
         end
      end
   endtask

   task automatic run_cycle();
      drive_inputs();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1 cyc++;
   endtask

   // Reset lands between edges with requests and a response on the pins.
   task automatic do_reset();
      c_ren     = 2'b01;
      c_wen     = 2'b10;
      mem_ready = 1'b1;
      mem_valid = 1'b1;
      mem_rdata = 32'h1234_5678;
      #1 rst = 1'b1;
      #1 check_idle_outputs("midrst");
      c_ren     = '0;
      c_wen     = '0;
      mem_valid = 1'b0;
      mem_ready = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      reset_model();
   endtask

   initial begin
      rst       = 1'b0;
      c_ren     = '0;
      c_wen     = '0;
      c_addr    = '0;
      c_wdata   = '0;
      mem_ready = 1'b0;
      mem_valid = 1'b0;
      mem_rdata = '0;
      reset_model();
      #1 rst = 1'b1;
      #1 check_idle_outputs("por");
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      for (int p = 0; p < NPH; p++) begin
         start_pct = ph_start[p];
         stay_pct  = ph_stay[p];
         ren_pct   = ph_ren[p];
         ready_pct = ph_ready[p];
         valid_pct = ph_valid[p];
         repeat (ph_len[p]) run_cycle();
         if (p == 2) do_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
